// File: rtl/scurve_usb_drain.sv
// rtl/scurve_usb_drain.sv - FX2 slave-FIFO drain for the SCurve USB data FIFO (optional feature macro: SCURVE_USB_TRAILER_EN)
module scurve_usb_drain #(
  parameter int PKT_WORDS = 256
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        usb_data_fifo_empty,
  output logic        usb_data_fifo_rd_en,
  input  logic [15:0] usb_data_fifo_dout,
  input  logic        SCurve_Test_Done,
  input  logic        usb_flag_full_n,
  output logic        usb_slwr_n,
  output logic        usb_pktend_n,
  output logic [15:0] usb_fdata,
  output logic        Data_Transmit_Done,
  output logic [15:0] word_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_LAT    = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_PKTEND = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef SCURVE_USB_TRAILER_EN
  localparam logic [2:0] S_TRL0   = 3'd6;
  localparam logic [2:0] S_TRL1   = 3'd7;
`endif

  localparam logic [15:0] PKT_LAST = 16'(PKT_WORDS - 1);

  logic [2:0]  r_state;
  logic [15:0] r_fdata;
  logic [15:0] r_word_count;
  logic [15:0] r_pkt_cnt;
  logic        r_done_q;
  logic        r_done_pending;
  logic        r_clr_count;
`ifdef SCURVE_USB_TRAILER_EN
  logic [1:0]  r_gap;
  logic        w_trl_stb;
`endif

  logic        w_done_rise;
  logic        w_can_rd;
  logic        w_end_of_run;
  logic        w_wr_stb;
  logic        w_slwr;
  logic [15:0] w_pkt_inc;

  assign w_done_rise  = SCurve_Test_Done & ~r_done_q;
  // Draining always wins; end-of-run is only considered once the FIFO is empty.
  assign w_can_rd     = enable & ~usb_data_fifo_empty & usb_flag_full_n;
  assign w_end_of_run = enable & usb_data_fifo_empty & r_done_pending;
  assign w_pkt_inc    = (r_pkt_cnt == PKT_LAST) ? 16'd0 : r_pkt_cnt + 16'd1;
  assign w_wr_stb     = (r_state == S_WR) & usb_flag_full_n;
`ifdef SCURVE_USB_TRAILER_EN
  // Trailer strobes keep the 3-cycle minimum slwr_n period via r_gap.
  assign w_trl_stb    = ((r_state == S_TRL0) | (r_state == S_TRL1)) & usb_flag_full_n & (r_gap == 2'd0);
  assign w_slwr       = w_wr_stb | w_trl_stb;
`else
  assign w_slwr       = w_wr_stb;
`endif

  // Strobes decode from state so none can be active on the cycle after reset.
  assign usb_data_fifo_rd_en = (r_state == S_RD);
  assign usb_slwr_n          = ~w_slwr;
  assign usb_pktend_n        = ~((r_state == S_PKTEND) & usb_flag_full_n);
  assign Data_Transmit_Done  = (r_state == S_DONE);
  assign usb_fdata           = r_fdata;
  assign word_count          = r_word_count;

  // Transfer FSM plus word/packet counters and end-of-run arming.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_fdata        <= 16'd0;
      r_word_count   <= 16'd0;
      r_pkt_cnt      <= 16'd0;
      r_done_q       <= 1'b0;
      r_done_pending <= 1'b0;
      r_clr_count    <= 1'b0;
`ifdef SCURVE_USB_TRAILER_EN
      r_gap          <= 2'd0;
`endif
    end else begin
      r_done_q <= SCurve_Test_Done;
      // A new edge landing on the DONE cycle belongs to the next run, so set wins.
      if (w_done_rise)
        r_done_pending <= 1'b1;
      else if (r_state == S_DONE)
        r_done_pending <= 1'b0;
`ifdef SCURVE_USB_TRAILER_EN
      if (w_slwr)
        r_gap <= 2'd2;
      else if (r_gap != 2'd0)
        r_gap <= r_gap - 2'd1;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_can_rd) begin
            r_state <= S_RD;
          end else if (w_end_of_run) begin
`ifdef SCURVE_USB_TRAILER_EN
            r_fdata <= 16'hFF45;
            r_state <= S_TRL0;
`else
            r_state <= (r_pkt_cnt != 16'd0) ? S_PKTEND : S_DONE;
`endif
          end
        end
        S_RD: begin
          if (r_clr_count) begin
            r_word_count <= 16'd0;
            r_clr_count  <= 1'b0;
          end
          r_state <= S_LAT;
        end
        S_LAT: begin
          r_fdata <= usb_data_fifo_dout;
          r_state <= S_WR;
        end
        S_WR: begin
          if (usb_flag_full_n) begin
            r_word_count <= r_word_count + 16'd1;
            r_pkt_cnt    <= w_pkt_inc;
            // Chaining straight into RD gives one word every 3 cycles.
            r_state      <= w_can_rd ? S_RD : S_IDLE;
          end
        end
`ifdef SCURVE_USB_TRAILER_EN
        S_TRL0: begin
          if (w_trl_stb) begin
            r_pkt_cnt <= w_pkt_inc;
            r_fdata   <= r_word_count;
            r_state   <= S_TRL1;
          end
        end
        S_TRL1: begin
          if (w_trl_stb) begin
            r_pkt_cnt <= w_pkt_inc;
            r_state   <= (w_pkt_inc != 16'd0) ? S_PKTEND : S_DONE;
          end
        end
`endif
        S_PKTEND: begin
          if (usb_flag_full_n) begin
            r_pkt_cnt <= 16'd0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_clr_count <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scurve_usb_drain.sv
// tb/tb_scurve_usb_drain.sv - scoreboard bench for scurve_usb_drain
module tb_scurve_usb_drain;

  localparam int PKT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        rd_en;
  logic [15:0] fifo_dout = 16'd0;
  logic        test_done = 1'b0;
  logic        full_n = 1'b1;
  logic        slwr_n;
  logic        pktend_n;
  logic [15:0] fdata;
  logic        xfer_done;
  logic [15:0] wcount;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] fifo_q[$];
  int          cyc = 0;
  int          last_wr = 0;
  bit          have_last = 0;
  int          first_wr = 0;
  bit          first_set = 0;
  int          prev_wc = 0;

  scurve_usb_drain #(.PKT_WORDS(PKT)) dut (
    .Clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .usb_data_fifo_empty (fifo_empty),
    .usb_data_fifo_rd_en (rd_en),
    .usb_data_fifo_dout  (fifo_dout),
    .SCurve_Test_Done    (test_done),
    .usb_flag_full_n     (full_n),
    .usb_slwr_n          (slwr_n),
    .usb_pktend_n        (pktend_n),
    .usb_fdata           (fdata),
    .Data_Transmit_Done  (xfer_done),
    .word_count          (wcount)
  );

  always #5 clk = ~clk;

  // Source FIFO model: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL fifo_underflow: rd_en with %0d words, required >0", fifo_q.size());
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check_ev(input logic [1:0] kind, input logic [15:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: kind %0d data %h, required none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data) begin
        failures++;
        $display("FAIL event_order: kind %0d data %h, required kind %0d data %h", kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: pop the scoreboard on every FX2-side event.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (!slwr_n || !pktend_n) begin
        checks++;
        if (!slwr_n && !pktend_n) begin
          failures++;
          $display("FAIL strobe_overlap: slwr_n=%b pktend_n=%b, required not both 0", slwr_n, pktend_n);
        end
      end
      if (!slwr_n) begin
        checks++;
        if (!full_n) begin
          failures++;
          $display("FAIL slwr_while_full: full_n=%b, required 1", full_n);
        end
        if (have_last) begin
          checks++;
          if (cyc - last_wr < 3) begin
            failures++;
            $display("FAIL slwr_period: %0d cycles, required >=3", cyc - last_wr);
          end
        end
        last_wr = cyc;
        have_last = 1;
        if (!first_set) begin
          first_wr = cyc;
          first_set = 1;
        end
        check_ev(2'd0, fdata);
      end
      if (!pktend_n) check_ev(2'd1, 16'd0);
      if (xfer_done) check_ev(2'd2, wcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_io();
    enable = ($urandom_range(0, 9) != 0);
    full_n = ($urandom_range(0, 4) != 0);
  endtask

  task automatic expect_eq(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // mode 0: preloaded, full speed; mode 1: random traffic; mode 2: full_n stall on word 2.
  task automatic run(input int n, input int mode);
    logic [15:0] words[$];
    int wc_exp;
    int total;
    int idx;
    int budget;
    int seen;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    wc_exp = (n > 0) ? n : prev_wc;
    total = n;
    for (int i = 0; i < n; i++) exp_q.push_back({2'd0, words[i]});
`ifdef SCURVE_USB_TRAILER_EN
    exp_q.push_back({2'd0, 16'hFF45});
    exp_q.push_back({2'd0, 16'(wc_exp)});
    total = n + 2;
`endif
    if (total % PKT != 0) exp_q.push_back({2'd1, 16'd0});
    exp_q.push_back({2'd2, 16'(wc_exp)});
    first_set = 0;
    enable = 1'b1;
    full_n = 1'b1;
    if (mode == 1) begin
      idx = 0;
      while (idx < n) begin
        tick();
        rand_io();
        if ($urandom_range(0, 1) == 1) begin
          fifo_q.push_back(words[idx]);
          idx++;
        end
      end
    end else begin
      for (int i = 0; i < n; i++) fifo_q.push_back(words[i]);
    end
    if (mode == 2) begin
      seen = 0;
      budget = 200;
      while (seen < 2 && budget > 0) begin
        tick();
        budget--;
        if (rd_en) seen++;
      end
      checks++;
      if (seen < 2) begin
        failures++;
        $display("FAIL stall_setup: saw %0d reads, required 2", seen);
      end
      tick();
      full_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        expect_eq("stall_slwr_n", {15'd0, slwr_n}, 16'd1);
        expect_eq("stall_fdata", fdata, words[1]);
      end
      full_n = 1'b1;
    end
    test_done = 1'b1;
    seen = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (mode == 1) rand_io();
      if (k == 1) test_done = 1'b0;
      if (xfer_done && seen == 0) seen = k;
    end
    test_done = 1'b0;
`ifndef SCURVE_USB_TRAILER_EN
    if (mode == 0 && n == 0) begin
      checks++;
      if (seen == 0 || seen > 2) begin
        failures++;
        $display("FAIL empty_done_latency: %0d cycles, required 1..2", seen);
      end
    end
`endif
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      if (mode == 1) rand_io();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL run_timeout: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    enable = 1'b1;
    full_n = 1'b1;
    tick();
    tick();
    expect_eq("word_count_hold", wcount, 16'(wc_exp));
`ifndef SCURVE_USB_TRAILER_EN
    if (mode == 0 && n >= 2) begin
      checks++;
      if (last_wr - first_wr != 3 * (n - 1)) begin
        failures++;
        $display("FAIL throughput_span: %0d cycles, required %0d", last_wr - first_wr, 3 * (n - 1));
      end
    end
`endif
    prev_wc = wc_exp;
  endtask

  task automatic reset_values(input string tag);
    expect_eq({tag, "_rd_en"}, {15'd0, rd_en}, 16'd0);
    expect_eq({tag, "_slwr_n"}, {15'd0, slwr_n}, 16'd1);
    expect_eq({tag, "_pktend_n"}, {15'd0, pktend_n}, 16'd1);
    expect_eq({tag, "_fdata"}, fdata, 16'd0);
    expect_eq({tag, "_done"}, {15'd0, xfer_done}, 16'd0);
    expect_eq({tag, "_word_count"}, wcount, 16'd0);
  endtask

  task automatic reset_in_lat();
    int budget;
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'($urandom));
    budget = 100;
    while (!rd_en && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (!rd_en) begin
      failures++;
      $display("FAIL reset_setup: rd_en=%b, required 1", rd_en);
    end
    tick();
    reset_n = 1'b0;
    fifo_q.delete();
    tick();
    reset_values("mid_reset");
    reset_n = 1'b1;
    exp_q.delete();
    have_last = 0;
    prev_wc = 0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_values("reset");
    reset_n = 1'b1;
    tick();
    run(0, 0);
    run(3, 0);
    run(8, 0);
    run(2, 0);
    run(5, 2);
    reset_in_lat();
    run(2, 0);
    for (int r = 0; r < 14; r++) run($urandom_range(0, 11), 1);
    run(4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
